// File: rtl/jelly_bean_pkg.sv
// Shared types for the jelly bean tasting scheduler.
//   flavor_e / color_e / taste_e / command_e : taster bus encodings
//   sched_state_e                            : scheduler FSM states
//   is_tasteable()                           : the taster ignores NO_FLAVOR
package jelly_bean_pkg;

  localparam int FLAVOR_W = 3;
  localparam int COLOR_W  = 2;
  localparam int TASTE_W  = 2;
  localparam int CMD_W    = 2;

  typedef enum logic [FLAVOR_W-1:0] {
    NO_FLAVOR,
    APPLE,
    BLUEBERRY,
    BUBBLE_GUM,
    CHOCOLATE
  } flavor_e;

  typedef enum logic [COLOR_W-1:0] {
    RED,
    GREEN,
    BLUE
  } color_e;

  typedef enum logic [TASTE_W-1:0] {
    UNKNOWN,
    YUMMY,
    YUCKY
  } taste_e;

  typedef enum logic [CMD_W-1:0] {
    NO_OP,
    READ,
    WRITE,
    CLR_WR
  } command_e;

  // ST_ prefix keeps these apart from the READ/WRITE bus commands.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } sched_state_e;

  function automatic logic is_tasteable(input logic [FLAVOR_W-1:0] flavor);
    return flavor != NO_FLAVOR;
  endfunction

endpackage

// File: rtl/jelly_bean_rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector
//   rr_ptr  : index with the highest priority this round
//   win     : one-hot winner (all zero when no request)
//   win_idx : index of the winner (0 when no request)
// The winner is the first set bit at or after rr_ptr, searching upward
// with wrap-around at NUM_REQ-1 (NUM_REQ need not be a power of two).
module jelly_bean_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [ID_W-1:0]    win_idx
);

  logic            found;
  int              pos;
  logic [ID_W-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = ID_W'(pos);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/jelly_bean_tasting_scheduler.sv
// Shares one jelly_bean_taster between NUM_REQ requesters.
// Each accepted request becomes a WRITE then a READ on the taster bus; the
// taste is returned on a shared response bus and tallied in saturating
// YUMMY/YUCKY counters.
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   req, req_flavor, req_color,
//   req_sugar_free, req_sour    : per-requester request and bean fields
//   gnt                         : one-hot one-cycle acceptance pulse
//   rsp_valid, rsp_id, rsp_taste: one-cycle response strobe and payload
//   tb_command .. tb_sour       : taster bus outputs
//   tb_taste                    : taste from the taster
//   busy                        : FSM not in IDLE
//   yummy_cnt, yucky_cnt        : saturating statistics
//
// state    | meaning
// ST_IDLE  | arbitrate, grant winner, capture its bean and index
// ST_WRITE | WRITE bus cycle carrying the captured bean
// ST_READ  | READ bus cycle, taste sampled at its end
// ST_RESP  | response strobe (NO_FLAVOR requests spend one extra cycle here)
module jelly_bean_tasting_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_flavor,
  input  logic [2*NUM_REQ-1:0] req_color,
  input  logic [NUM_REQ-1:0]   req_sugar_free,
  input  logic [NUM_REQ-1:0]   req_sour,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           rsp_taste,
  output logic [1:0]           tb_command,
  output logic [2:0]           tb_flavor,
  output logic [1:0]           tb_color,
  output logic                 tb_sugar_free,
  output logic                 tb_sour,
  input  logic [1:0]           tb_taste,
  output logic                 busy,
  output logic [CNT_W-1:0]     yummy_cnt,
  output logic [CNT_W-1:0]     yucky_cnt
);

  import jelly_bean_pkg::*;

  sched_state_e        state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cap_id;

  logic [NUM_REQ-1:0]  win;
  logic [ID_W-1:0]     win_idx;
  logic [2:0]          win_flavor;
  logic [1:0]          win_color;
  logic                win_sugar_free;
  logic                win_sour;

  jelly_bean_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // One-hot mux of the winner's bean fields.
  always_comb begin
    win_flavor     = '0;
    win_color      = '0;
    win_sugar_free = 1'b0;
    win_sour       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_flavor     = win_flavor | (req_flavor[3*i +: 3] & {3{win[i]}});
      win_color      = win_color  | (req_color[2*i +: 2]  & {2{win[i]}});
      win_sugar_free = win_sugar_free | (req_sugar_free[i] & win[i]);
      win_sour       = win_sour       | (req_sour[i]       & win[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      cap_id        <= '0;
      gnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_taste     <= UNKNOWN;
      tb_command    <= NO_OP;
      tb_flavor     <= NO_FLAVOR;
      tb_color      <= '0;
      tb_sugar_free <= 1'b0;
      tb_sour       <= 1'b0;
      busy          <= 1'b0;
      yummy_cnt     <= '0;
      yucky_cnt     <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt    <= win;
            cap_id <= win_idx;
            busy   <= 1'b1;
            rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);
            if (is_tasteable(win_flavor)) begin
              state         <= ST_WRITE;
              tb_command    <= WRITE;
              tb_flavor     <= win_flavor;
              tb_color      <= win_color;
              tb_sugar_free <= win_sugar_free;
              tb_sour       <= win_sour;
            end else begin
              // Taster ignores NO_FLAVOR, so answer UNKNOWN without touching it.
              state <= ST_RESP;
            end
          end
        end

        ST_WRITE: begin
          // NO_FLAVOR on the READ keeps the taster's taste register intact.
          state         <= ST_READ;
          tb_command    <= READ;
          tb_flavor     <= NO_FLAVOR;
          tb_color      <= '0;
          tb_sugar_free <= 1'b0;
          tb_sour       <= 1'b0;
        end

        ST_READ: begin
          state      <= ST_RESP;
          tb_command <= NO_OP;
          rsp_valid  <= 1'b1;
          rsp_id     <= cap_id;
          rsp_taste  <= tb_taste;
          if (tb_taste == YUMMY && yummy_cnt != '1) yummy_cnt <= yummy_cnt + CNT_W'(1);
          if (tb_taste == YUCKY && yucky_cnt != '1) yucky_cnt <= yucky_cnt + CNT_W'(1);
        end

        ST_RESP: begin
          if (rsp_valid) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            // Arrived straight from IDLE with a NO_FLAVOR bean.
            rsp_valid <= 1'b1;
            rsp_id    <= cap_id;
            rsp_taste <= UNKNOWN;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jelly_bean_tasting_scheduler.sv
module tb_jelly_bean_tasting_scheduler;
  import jelly_bean_pkg::*;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_flavor;
  logic [2*NUM_REQ-1:0] req_color;
  logic [NUM_REQ-1:0]   req_sugar_free;
  logic [NUM_REQ-1:0]   req_sour;
  logic [NUM_REQ-1:0]   gnt;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [1:0]           rsp_taste;
  logic [1:0]           tb_command;
  logic [2:0]           tb_flavor;
  logic [1:0]           tb_color;
  logic                 tb_sugar_free;
  logic                 tb_sour;
  logic [1:0]           tb_taste = 2'd0;
  logic                 busy;
  logic [15:0]          yummy_cnt;
  logic [15:0]          yucky_cnt;

  // Second instance with 2-bit counters to observe saturation.
  logic [NUM_REQ-1:0]   s_gnt;
  logic                 s_rsp_valid;
  logic [1:0]           s_rsp_id;
  logic [1:0]           s_rsp_taste;
  logic [1:0]           s_tb_command;
  logic [2:0]           s_tb_flavor;
  logic [1:0]           s_tb_color;
  logic                 s_tb_sugar_free;
  logic                 s_tb_sour;
  logic                 s_busy;
  logic [1:0]           s_yummy_cnt;
  logic [1:0]           s_yucky_cnt;

  int checks = 0;
  int errors = 0;
  int exp_yummy = 0;
  int exp_yucky = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] taste;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  jelly_bean_tasting_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_flavor(req_flavor),
    .req_color(req_color), .req_sugar_free(req_sugar_free), .req_sour(req_sour),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_taste(rsp_taste),
    .tb_command(tb_command), .tb_flavor(tb_flavor), .tb_color(tb_color),
    .tb_sugar_free(tb_sugar_free), .tb_sour(tb_sour), .tb_taste(tb_taste),
    .busy(busy), .yummy_cnt(yummy_cnt), .yucky_cnt(yucky_cnt)
  );

  jelly_bean_tasting_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .req_flavor(req_flavor),
    .req_color(req_color), .req_sugar_free(req_sugar_free), .req_sour(req_sour),
    .gnt(s_gnt), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_taste(s_rsp_taste),
    .tb_command(s_tb_command), .tb_flavor(s_tb_flavor), .tb_color(s_tb_color),
    .tb_sugar_free(s_tb_sugar_free), .tb_sour(s_tb_sour), .tb_taste(tb_taste),
    .busy(s_busy), .yummy_cnt(s_yummy_cnt), .yucky_cnt(s_yucky_cnt)
  );

  // Taster model: a WRITE with a real flavor sets the taste; anything else holds it.
  always @(posedge clk) begin
    if (tb_command == WRITE && tb_flavor != NO_FLAVOR)
      tb_taste <= (tb_flavor == CHOCOLATE && tb_sour) ? YUCKY : YUMMY;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed id %0d taste %0d expected no response", rsp_id, rsp_taste);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_taste", 32'(rsp_taste), 32'(mon_e.taste));
      end
    end
  end

  task automatic count_exp(input logic [1:0] t);
    if (t == YUMMY) exp_yummy++;
    else if (t == YUCKY) exp_yucky++;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_yummy"}, 32'(yummy_cnt), 32'(exp_yummy));
    check({tag, "_yucky"}, 32'(yucky_cnt), 32'(exp_yucky));
    check({tag, "_sat_yummy"}, 32'(s_yummy_cnt), 32'((exp_yummy > 3) ? 3 : exp_yummy));
    check({tag, "_sat_yucky"}, 32'(s_yucky_cnt), 32'((exp_yucky > 3) ? 3 : exp_yucky));
  endtask

  task automatic set_fields(input int id, input logic [2:0] flv, input logic [1:0] col,
                            input logic sf, input logic sr);
    req_flavor[3*id +: 3] = flv;
    req_color[2*id +: 2]  = col;
    req_sugar_free[id]    = sf;
    req_sour[id]          = sr;
  endtask

  // Asserts reset at a falling edge, checks outputs immediately, releases one cycle later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_yummy = 0;
    exp_yucky = 0;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_taste", 32'(rsp_taste), 32'(UNKNOWN));
    check("rst_tb_command", 32'(tb_command), 32'(NO_OP));
    check("rst_tb_flavor", 32'(tb_flavor), 32'(NO_FLAVOR));
    check("rst_tb_color", 32'(tb_color), 0);
    check("rst_tb_sf", 32'(tb_sugar_free), 0);
    check("rst_tb_sour", 32'(tb_sour), 0);
    check("rst_busy", 32'(busy), 0);
    check_counters("rst");
    @(negedge clk);
    check("rst_hold_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
  endtask

  // Single request from an idle scheduler; starts and ends on a falling edge.
  // With keep=0 it stops at the READ cycle (caller then resets).
  task automatic send(input int id, input logic [2:0] flv, input logic [1:0] col,
                      input logic sf, input logic sr, input logic [1:0] tst, input bit keep);
    set_fields(id, flv, col, sf, sr);
    req[id] = 1'b1;
    if (keep) sb.push_back('{id: 2'(id), taste: tst});
    @(negedge clk);
    check("gnt_c1", 32'(gnt), 32'(1 << id));
    check("busy_c1", 32'(busy), 1);
    req[id] = 1'b0;
    if (flv != NO_FLAVOR) begin
      check("wr_cmd", 32'(tb_command), 32'(WRITE));
      check("wr_flavor", 32'(tb_flavor), 32'(flv));
      check("wr_color", 32'(tb_color), 32'(col));
      check("wr_sf", 32'(tb_sugar_free), 32'(sf));
      check("wr_sour", 32'(tb_sour), 32'(sr));
      @(negedge clk);
      check("rd_cmd", 32'(tb_command), 32'(READ));
      check("rd_flavor", 32'(tb_flavor), 32'(NO_FLAVOR));
      check("rd_gnt", 32'(gnt), 0);
      check("rd_rsp_valid", 32'(rsp_valid), 0);
      if (!keep) return;
      @(negedge clk);
      check("rsp_valid_c3", 32'(rsp_valid), 1);
      count_exp(tst);
      check_counters("c3");
      @(negedge clk);
      check("rsp_valid_c4", 32'(rsp_valid), 0);
      check("busy_c4", 32'(busy), 0);
    end else begin
      check("nf_cmd_c1", 32'(tb_command), 32'(NO_OP));
      check("nf_flavor_c1", 32'(tb_flavor), 32'(NO_FLAVOR));
      check("nf_rsp_valid_c1", 32'(rsp_valid), 0);
      @(negedge clk);
      check("nf_rsp_valid_c2", 32'(rsp_valid), 1);
      check("nf_cmd_c2", 32'(tb_command), 32'(NO_OP));
      check_counters("nf");
      @(negedge clk);
      check("nf_rsp_valid_c3", 32'(rsp_valid), 0);
      check("nf_busy_c3", 32'(busy), 0);
      check("nf_cmd_c3", 32'(tb_command), 32'(NO_OP));
    end
  endtask

  initial begin
    int order[5];
    int last_cyc;
    int cyc;
    bit found;
    order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req = '0;
    req_flavor = '0;
    req_color = '0;
    req_sugar_free = '0;
    req_sour = '0;
    @(negedge clk);
    do_reset();

    // Single APPLE request from requester 2.
    send(2, APPLE, RED, 1'b0, 1'b0, YUMMY, 1'b1);
    // CHOCOLATE sour from requester 0.
    send(0, CHOCOLATE, BLUE, 1'b1, 1'b1, YUCKY, 1'b1);
    // NO_FLAVOR from requester 1: short path, taster untouched.
    send(1, NO_FLAVOR, GREEN, 1'b0, 1'b0, UNKNOWN, 1'b1);

    // All requesters held high after reset: 0,1,2,3,0 four cycles apart.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_fields(i, APPLE, 2'(i % 3), 1'(i % 2), 1'b0);
    for (int k = 0; k < 5; k++) sb.push_back('{id: 2'(order[k]), taste: YUMMY});
    req = '1;
    cyc = 0;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk);
        cyc++;
        if (gnt != '0) found = 1'b1;
      end
      check("rr_gnt_seen", 32'(found), 1);
      check("rr_gnt", 32'(gnt), 32'(1 << order[k]));
      if (k > 0) check("rr_gap", 32'(cyc - last_cyc), 4);
      last_cyc = cyc;
    end
    req = '0;
    repeat (4) @(negedge clk);
    exp_yummy = 5;
    check_counters("rr");
    check("rr_sat_yummy_at_max", 32'(s_yummy_cnt), 3);

    // Reset during the READ cycle of a requester-1 transaction.
    send(1, BLUEBERRY, GREEN, 1'b1, 1'b0, YUMMY, 1'b0);
    do_reset();
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 0);

    // After release the pointer is back at 0: requester 1 beats requester 3.
    set_fields(1, APPLE, RED, 1'b0, 1'b0);
    set_fields(3, CHOCOLATE, BLUE, 1'b0, 1'b1);
    sb.push_back('{id: 2'd1, taste: YUMMY});
    sb.push_back('{id: 2'd3, taste: YUCKY});
    req = 4'b1010;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_gnt2", 32'(gnt), 32'b1000);
    req[3] = 1'b0;
    repeat (4) @(negedge clk);
    exp_yummy = 1;
    exp_yucky = 1;
    check_counters("final");
    check("final_busy", 32'(busy), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jelly_bean_tasting_scheduler.md
# jelly_bean_tasting_scheduler

Shares one `jelly_bean_taster` between `NUM_REQ` requesters. Requests are accepted in round-robin order. For each accepted request the block sequences a WRITE then a READ on the taster bus, captures the taste and returns it on a shared response bus. It also keeps saturating YUMMY/YUCKY statistics. It sits between the requester agents and the taster's slave interface.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 16, width of statistics counters

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset is asynchronous and active-low
- `req`  in  NUM_REQ  per-requester request, held until `gnt`
- `req_flavor`  in  3*NUM_REQ  flavor field, slice i for requester i
- `req_color`  in  2*NUM_REQ  color field
- `req_sugar_free`  in  NUM_REQ  sugar-free flag
- `req_sour`  in  NUM_REQ  sour flag
- `gnt`  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- `rsp_valid`  out  1  one-cycle response strobe, no backpressure
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the response
- `rsp_taste`  out  2  taste result
- `tb_command`  out  2  taster command
- `tb_flavor`  out  3  taster flavor
- `tb_color`  out  2  taster color
- `tb_sugar_free`  out  1  taster sugar-free flag
- `tb_sour`  out  1  taster sour flag
- `tb_taste`  in  2  taste from the taster
- `busy`  out  1  high in any state other than IDLE
- `yummy_cnt`  out  CNT_W  YUMMY responses, saturating
- `yucky_cnt`  out  CNT_W  YUCKY responses, saturating

## Operation
- FSM states: IDLE, WRITE, READ, RESP. All outputs are registered.
- Requester inputs are sampled only in IDLE.
- IDLE:
  - If any `req` is high, the winner is the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Pulse the winner's `gnt` bit.
  - Capture the winner's fields and index.
  - Set `rr_ptr` to winner+1, wrapping to 0 after NUM_REQ-1.
  - If the captured flavor is NO_FLAVOR, go to RESP with taste UNKNOWN. The taster is not touched, because it ignores NO_FLAVOR.
  - Otherwise go to WRITE.
- WRITE: drive `tb_command`=WRITE and the captured fields for exactly one cycle, then go to READ.
- READ:
  - Drive `tb_command`=READ with `tb_flavor`=NO_FLAVOR so the taster's taste holds.
  - At the end of the cycle, sample `tb_taste` into the result register.
  - Go to RESP.
- RESP:
  - Pulse `rsp_valid` with `rsp_id` and `rsp_taste`.
  - Increment `yummy_cnt` or `yucky_cnt` according to the taste. UNKNOWN increments neither.
  - Counters stop at all-ones.
  - Go to IDLE.
- Outside WRITE and READ, drive `tb_command`=NO_OP and `tb_flavor`=NO_FLAVOR.
- Requests that are not granted keep waiting. No request is dropped.

## Timing
- Reset values:
  - FSM in IDLE, `rr_ptr`=0.
  - `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_taste`=UNKNOWN.
  - `tb_command`=NO_OP, `tb_flavor`=NO_FLAVOR, `tb_color`=0, `tb_sugar_free`=0, `tb_sour`=0.
  - `busy`=0, both counters 0.
- Normal request, counting from the edge where `req` is seen in IDLE (edge 0):
  - `gnt` is high in cycle 1.
  - WRITE bus cycle is cycle 1.
  - READ bus cycle is cycle 2.
  - `rsp_valid` is high in cycle 3.
  - A new grant is possible in cycle 4.
  - Throughput is one request per 4 cycles.
- NO_FLAVOR request: `gnt` in cycle 1, `rsp_valid` in cycle 2.
- Requester i must hold its fields stable until it sees its `gnt` bit.
- A requester may deassert `req` before it is granted. It is then simply not granted.
- Re-asserting `req` in the cycle after `gnt` is a new request.
- Simultaneous requests: only one is granted per IDLE. Round-robin order guarantees each requester waits at most NUM_REQ-1 other transactions.
- Reset asserted mid-transaction: all state returns to reset values immediately and the in-flight response is lost. The taster's taste is not reset, but the next WRITE overwrites it.

## Structure
- `jelly_bean_pkg::jelly_bean_types` holds the shared enums:
  - flavor_e: NO_FLAVOR, APPLE, BLUEBERRY, BUBBLE_GUM, CHOCOLATE
  - color_e: RED, GREEN, BLUE
  - taste_e: UNKNOWN, YUMMY, YUCKY
  - command_e: NO_OP, READ, WRITE, CLR_WR
  - New: sched_state_e: IDLE, WRITE, READ, RESP
- The round-robin selector is a natural sub-module: `jelly_bean_rr_arbiter`, with inputs `req` and `rr_ptr` and outputs one-hot `win` and `win_idx`. It is purely combinational.

## Test plan
- Single request: requester 2 sends APPLE, sour=0 -> `gnt`[2] in cycle 1, WRITE bus cycle in cycle 1, `rsp_valid` in cycle 3 with `rsp_id`=2 and taste YUMMY, `yummy_cnt`=1.
- CHOCOLATE with sour=1 from requester 0 -> `rsp_taste`=YUCKY, `yucky_cnt`=1, `yummy_cnt` unchanged.
- All 4 `req` bits held high after reset -> grant order 0,1,2,3,0, `gnt` pulses spaced 4 cycles apart.
- NO_FLAVOR from requester 1 -> `rsp_valid` in cycle 2 with taste UNKNOWN, `tb_command` stays NO_OP throughout, counters unchanged.
- `rst_n` asserted during READ -> next cycle all outputs at reset values, no `rsp_valid`. A request after release is granted to the lowest index ≥ 0.
- CNT_W=2 with 5 YUMMY requests -> `yummy_cnt` saturates at 3.
